// File: rtl/enc_lag3_seq_pkg.sv
// Shared types and constants for the Enc_lag3 two-subframe sequencer.
package enc_lag3_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD0,
        GO0,
        GUARD0,
        WAIT0,
        LOAD1,
        GO1,
        GUARD1,
        WAIT1,
        FIN
    } state_e;

    localparam int L_SUBFR_DEFAULT = 40;
    localparam int TMO_CNT_W       = 16;

endpackage

// File: rtl/enc_lag3_watchdog.sv
// Counts cycles spent in a WAITn state and flags the cycle on which the wait limit is reached.
module enc_lag3_watchdog
    import enc_lag3_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside WAITn, so every entry into a wait starts from a cleared count.
    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = cnt_q + TMO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/enc_lag3_seq.sv
// Sequences two Enc_lag3 runs per frame (subframe 0, then subframe 1) and collects their indices.
// Optional WAITn watchdog with sticky timeout_err: define ENC_LAG3_SEQ_TIMEOUT_EN.
module enc_lag3_seq
    import enc_lag3_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int L_SUBFR        = L_SUBFR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] T0_sf0,
    input  logic [15:0] T0_frac_sf0,
    input  logic [15:0] T0_sf1,
    input  logic [15:0] T0_frac_sf1,
    input  logic        lag_done,
    input  logic [15:0] lag_index,
    output logic        lag_start,
    output logic [15:0] T0,
    output logic [15:0] T0_frac,
    output logic [15:0] pit_flag,
    output logic        Enc_lag3MuxSel,
    output logic [15:0] index0,
    output logic [15:0] index1,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output state_e      dbg_state
);

    state_e      state_q, state_d;
    logic [15:0] sf0_t0_q, sf0_t0_d, sf0_frac_q, sf0_frac_d;
    logic [15:0] sf1_t0_q, sf1_t0_d, sf1_frac_q, sf1_frac_d;
    logic [15:0] t0_q, t0_d, t0_frac_q, t0_frac_d, pit_flag_q, pit_flag_d;
    logic [15:0] index0_q, index0_d, index1_q, index1_d;
    logic        lag_start_q, lag_start_d, mux_sel_q, mux_sel_d, done_q, done_d;
    logic        start_acc, wd_expired;

    // Operand outputs only change on the transitions into LOAD0/LOAD1, so they stay stable through WAITn.
    always_comb begin
        state_d    = state_q;
        sf0_t0_d   = sf0_t0_q;
        sf0_frac_d = sf0_frac_q;
        sf1_t0_d   = sf1_t0_q;
        sf1_frac_d = sf1_frac_q;
        t0_d       = t0_q;
        t0_frac_d  = t0_frac_q;
        pit_flag_d = pit_flag_q;
        mux_sel_d  = mux_sel_q;
        index0_d   = index0_q;
        index1_d   = index1_q;
        start_acc  = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                start_acc  = 1'b1;
                sf0_t0_d   = T0_sf0;
                sf0_frac_d = T0_frac_sf0;
                sf1_t0_d   = T0_sf1;
                sf1_frac_d = T0_frac_sf1;
                t0_d       = T0_sf0;
                t0_frac_d  = T0_frac_sf0;
                pit_flag_d = 16'd0;
                mux_sel_d  = 1'b0;
                state_d    = LOAD0;
            end
            LOAD0:  state_d = GO0;
            GO0:    state_d = GUARD0;
            GUARD0: state_d = WAIT0;
            WAIT0: if (lag_done || wd_expired) begin
                index0_d   = lag_done ? lag_index : 16'hFFFF;
                t0_d       = sf1_t0_q;
                t0_frac_d  = sf1_frac_q;
                pit_flag_d = 16'(L_SUBFR);
                state_d    = LOAD1;
            end
            LOAD1:  state_d = GO1;
            GO1:    state_d = GUARD1;
            GUARD1: state_d = WAIT1;
            WAIT1: if (lag_done || wd_expired) begin
                index1_d  = lag_done ? lag_index : 16'hFFFF;
                mux_sel_d = 1'b1;
                state_d   = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        lag_start_d = (state_d == GO0) || (state_d == GO1);
        done_d      = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sf0_t0_q    <= '0;
            sf0_frac_q  <= '0;
            sf1_t0_q    <= '0;
            sf1_frac_q  <= '0;
            t0_q        <= '0;
            t0_frac_q   <= '0;
            pit_flag_q  <= '0;
            index0_q    <= '0;
            index1_q    <= '0;
            lag_start_q <= 1'b0;
            mux_sel_q   <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sf0_t0_q    <= sf0_t0_d;
            sf0_frac_q  <= sf0_frac_d;
            sf1_t0_q    <= sf1_t0_d;
            sf1_frac_q  <= sf1_frac_d;
            t0_q        <= t0_d;
            t0_frac_q   <= t0_frac_d;
            pit_flag_q  <= pit_flag_d;
            index0_q    <= index0_d;
            index1_q    <= index1_d;
            lag_start_q <= lag_start_d;
            mux_sel_q   <= mux_sel_d;
            done_q      <= done_d;
        end
    end

`ifdef ENC_LAG3_SEQ_TIMEOUT_EN
    logic wd_run, tmo_err_q, tmo_err_d;

    assign wd_run = (state_q == WAIT0) || (state_q == WAIT1);

    enc_lag3_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (reset),
        .run    (wd_run),
        .expired(wd_expired)
    );

    always_comb begin
        tmo_err_d = tmo_err_q;
        if (start_acc) begin
            tmo_err_d = 1'b0;
        end else if (wd_expired) begin
            tmo_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    logic unused_tmo;

    assign unused_tmo  = (TIMEOUT_CYCLES == 0) || start_acc;
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign lag_start      = lag_start_q;
    assign T0             = t0_q;
    assign T0_frac        = t0_frac_q;
    assign pit_flag       = pit_flag_q;
    assign Enc_lag3MuxSel = mux_sel_q;
    assign index0         = index0_q;
    assign index1         = index1_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign dbg_state      = state_q;

endmodule
